prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 The block SHALL have parameter BASE_ADDR, default 8'h00, first instruction-memory address written.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to accept a new frame; honoured in DONE or ERR only.
REQ-006 The block SHALL have port in_valid  input  1  upstream byte valid.
REQ-007 The block SHALL have port in_data  input  8  upstream byte.
REQ-008 The block SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-009 The block SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per byte.
REQ-010 The block SHALL have port mem_addr  output  8  instruction-memory write address.
REQ-011 The block SHALL have port mem_wdata  output  8  instruction-memory write data.
REQ-012 The block SHALL have port cpu_hold  output  1  drives the PC reset and deasserts the PC enable; high while loading.
REQ-013 The block SHALL have port done  output  1  frame loaded successfully.
REQ-014 The block SHALL have port error  output  1  frame rejected.

Function
REQ-015 A byte SHALL transfer on a rising edge where in_valid and in_ready are both high; in_data is otherwise ignored.
REQ-016 The FSM states SHALL be SYNC, LEN, DATA, CSUM, DONE and ERR; in_ready SHALL be high in SYNC/LEN/DATA/CSUM and low in DONE/ERR.
REQ-017 In SYNC, a byte equal to SYNC_BYTE SHALL move to LEN; any other byte SHALL be discarded, remaining in SYNC without error.
REQ-018 In LEN, the accepted byte SHALL set the frame length N (1..255); value 0 SHALL mean N=256. Next state: DATA. Byte index and running sum SHALL clear.
REQ-019 In DATA, each accepted byte SHALL produce mem_we=1 on the following cycle only, with mem_wdata=byte and mem_addr=(BASE_ADDR+index) mod 256.
REQ-020 The running sum SHALL be the 8-bit modulo-256 sum of the data bytes.
REQ-021 The index SHALL be 9 bits wide so N=256 terminates correctly. Addresses SHALL wrap from 8'hFF to 8'h00.
REQ-022 After the Nth data byte, the FSM SHALL move to CSUM (macro defined) or DONE (macro undefined).
REQ-023 done SHALL be high exactly while in DONE. error SHALL be high exactly while in ERR.
REQ-024 cpu_hold SHALL be high in every state except DONE. It SHALL fall on the edge after DONE entry, so the final mem_we precedes CPU release.
REQ-025 start in DONE or ERR SHALL move to SYNC, raise cpu_hold and clear done/error. start in any other state SHALL be ignored.
REQ-026 When no data byte is being written, mem_we SHALL be 0; mem_addr and mem_wdata hold their last values.

Reset
REQ-027 Reset SHALL force state SYNC; in_ready=1 on the next cycle.
REQ-028 Reset SHALL force mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, and index=sum=N=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no further writes. Already-written memory SHALL be left untouched.
REQ-030 Reset SHALL take priority over start and byte transfers in the same cycle.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: one checksum byte SHALL follow the data. If it equals the running sum, the FSM SHALL enter DONE; otherwise it SHALL enter ERR. Data already written is not rolled back.
REQ-032 Macro LOADER_CHECKSUM_EN undefined: the CSUM state and sum logic SHALL be absent, and DONE SHALL follow the last data byte directly.

Verification
REQ-033 Stream 33,A5,03,10,20,30,60 with in_valid held, macro on -> writes (00,10),(01,20),(02,30); done=1; cpu_hold falls one cycle after done rises.
REQ-034 Same frame with checksum 61 -> three writes, then error=1, cpu_hold stays 1; a start pulse -> SYNC, error=0.
REQ-035 LEN=00 with 256 bytes, BASE_ADDR=8'h80 -> 256 writes, addresses 80..FF then 00..7F; done after the 256th byte (plus checksum if the macro is on).
REQ-036 in_valid toggled 1/0 every cycle during DATA -> writes only on accepted bytes, no duplicates or losses.
REQ-037 Reset asserted after the 2nd of 4 data bytes -> exactly 2 writes, then SYNC, cpu_hold=1, done=error=0; a new frame loads normally.
REQ-038 Macro off, frame A5,02,AA,BB -> two writes, done=1 with no checksum byte consumed; the next byte sees in_ready=0.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: takes a framed byte stream and writes it into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module prog_loader #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_hold,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_SYNC = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [8:0] len_q, len_d;
   logic [8:0] idx_q, idx_d;
   logic       we_q, we_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       hold_q, hold_d;
   logic       xfer;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
`endif

   assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
   assign xfer      = in_valid && in_ready;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_hold  = hold_q;
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERR);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_SYNC: begin
            if (xfer && (in_data == SYNC_BYTE)) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (xfer) begin
               // A zero length byte encodes a full 256-byte frame.
               len_d   = {(in_data == 8'd0), in_data};
               idx_d   = 9'd0;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = 8'd0;
`endif
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + idx_q[7:0];
               wdata_d = in_data;
               idx_d   = idx_q + 9'd1;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = sum_q + in_data;
               if (idx_d == len_q) begin
                  state_d = S_CSUM;
               end
`else
               if (idx_d == len_q) begin
                  state_d = S_DONE;
               end
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (xfer) begin
               state_d = (in_data == sum_q) ? S_DONE : S_ERR;
            end
         end
`endif
         S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_SYNC;
            end
         end
         default: begin
            state_d = S_SYNC;
         end
      endcase
      // Release the CPU one edge after DONE entry so the last write lands first.
      hold_d = !((state_q == S_DONE) && (state_d == S_DONE));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_SYNC;
         len_q   <= 9'd0;
         idx_q   <= 9'd0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= 8'd0;
         hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame bench for prog_loader; two instances with different base addresses.
// Expected writes and outcomes come from a frame-level model built while sending.
module tb_prog_loader;

   localparam logic [7:0] SB = 8'hA5;
   localparam logic [7:0] B0 = 8'h00;
   localparam logic [7:0] B1 = 8'h80;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       rdy [2];
   logic       we [2];
   logic       hold [2];
   logic       dn [2];
   logic       er [2];
   logic [7:0] addr [2];
   logic [7:0] wd [2];

   int total = 0;
   int bad = 0;

   logic [7:0]  expq [$];
   logic [15:0] got0 [$];
   logic [15:0] got1 [$];

   always #5 clk = ~clk;

   prog_loader u0 (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[0]), .mem_we(we[0]),
      .mem_addr(addr[0]), .mem_wdata(wd[0]),
      .cpu_hold(hold[0]), .done(dn[0]), .error(er[0])
   );

   prog_loader #(.SYNC_BYTE(SB), .BASE_ADDR(B1)) u1 (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[1]), .mem_we(we[1]),
      .mem_addr(addr[1]), .mem_wdata(wd[1]),
      .cpu_hold(hold[1]), .done(dn[1]), .error(er[1])
   );

   always @(negedge clk) begin
      if (we[0]) got0.push_back({addr[0], wd[0]});
      if (we[1]) got1.push_back({addr[1], wd[1]});
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic erdy,
                            input logic edn, input logic eer,
                            input logic ehold);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.rdy%0d", tag, k), 32'(rdy[k]), 32'(erdy));
         chk($sformatf("%s.done%0d", tag, k), 32'(dn[k]), 32'(edn));
         chk($sformatf("%s.err%0d", tag, k), 32'(er[k]), 32'(eer));
         chk($sformatf("%s.hold%0d", tag, k), 32'(hold[k]), 32'(ehold));
      end
   endtask

   task automatic cmp_writes(input string tag);
      logic [7:0] a;
      chk({tag, ".n0"}, 32'(got0.size()), 32'(expq.size()));
      chk({tag, ".n1"}, 32'(got1.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size(); i++) begin
         if (i < got0.size()) begin
            a = B0 + 8'(i);
            chk($sformatf("%s.w0[%0d]", tag, i), 32'(got0[i]), 32'({a, expq[i]}));
         end
         if (i < got1.size()) begin
            a = B1 + 8'(i);
            chk($sformatf("%s.w1[%0d]", tag, i), 32'(got1[i]), 32'({a, expq[i]}));
         end
      end
      got0.delete();
      got1.delete();
      expq.delete();
   endtask

   task automatic xfer(input logic [7:0] b, input bit noise);
      bit ok;
      in_valid = 1'b1;
      in_data  = b;
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rdy[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("xfer_ready", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         in_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_frame(input string tag, input int n, input bit bad_cs,
                            input bit gaps, input bit fixed);
      logic [7:0] b;
      logic [7:0] sum;
      bit exp_err;
      int j;
      j = $urandom_range(0, 3);
      repeat (j) begin
         b = 8'($urandom);
         if (b == SB) b = 8'h33;
         xfer(b, 1'b0);
      end
      xfer(SB, 1'b0);
      xfer((n == 256) ? 8'h00 : 8'(n), 1'b1);
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
         b = fixed ? 8'((i + 1) * 16) : 8'($urandom);
         expq.push_back(b);
         sum = sum + b;
         xfer(b, 1'b1);
         if (gaps && i < n - 1) idle(1);
      end
      exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (bad_cs) begin
         b = sum ^ 8'($urandom_range(1, 255));
         exp_err = 1'b1;
      end else begin
         b = sum;
      end
      xfer(b, 1'b0);
`else
      if (bad_cs) exp_err = 1'b0;
`endif
      @(negedge clk);
      chk_flags({tag, ".end"}, 1'b0, !exp_err, exp_err, 1'b1);
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         chk($sformatf("%s.hold_late%0d", tag, k), 32'(hold[k]), 32'(exp_err));
      @(posedge clk);
      #1;
      cmp_writes(tag);
      in_valid = 1'b1;
      repeat (3) begin
         in_data = 8'($urandom);
         @(negedge clk);
         chk_flags({tag, ".park"}, 1'b0, !exp_err, exp_err, exp_err);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, ".park_w0"}, 32'(got0.size()), 32'd0);
      chk({tag, ".park_w1"}, 32'(got1.size()), 32'd0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk_flags({tag, ".restart"}, 1'b1, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] b;
      reset = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      in_data = SB;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("reset.we0", 32'(we[0]), 32'd0);
      chk("reset.we1", 32'(we[1]), 32'd0);
      chk("reset.addr0", 32'(addr[0]), 32'(B0));
      chk("reset.addr1", 32'(addr[1]), 32'(B1));
      chk("reset.wd0", 32'(wd[0]), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;

      run_frame("f3_good", 3, 1'b0, 1'b0, 1'b1);
      run_frame("f3_bad", 3, 1'b1, 1'b0, 1'b1);
      run_frame("gaps", 9, 1'b0, 1'b1, 1'b0);
      run_frame("n1", 1, 1'b0, 1'b0, 1'b0);
      run_frame("n256", 256, 1'b0, 1'b0, 1'b0);

      xfer(SB, 1'b0);
      xfer(8'd4, 1'b0);
      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         expq.push_back(b);
         xfer(b, 1'b0);
      end
      reset = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk_flags("midrst", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("midrst.we0", 32'(we[0]), 32'd0);
      chk("midrst.addr1", 32'(addr[1]), 32'(B1));
      idle(3);
      cmp_writes("midrst");
      run_frame("after_rst", 4, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 5; r++)
         run_frame($sformatf("rnd%0d", r), $urandom_range(1, 20),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
